// File: rtl/sweep_acq_uploader_pkg.sv
// sweep_acq_uploader_pkg: shared FSM encoding, default trailer tags and DAC pad width.
package sweep_acq_uploader_pkg;
  typedef enum logic [2:0] {IDLE, STREAM, DRAIN, TAG, DAC, DONE_PULSE, END, END_PULSE} state_t;
  localparam logic [15:0] DAC_TAG_DEF = 16'hFFD0;
  localparam logic [15:0] END_TAG_DEF = 16'hFFEE;
  localparam int DAC_PAD_W = 6;
endpackage

// File: rtl/sweep_upload_fifo.sv
// sweep_upload_fifo: first-word-fall-through buffer; ports Clk/reset_n, wr_en/wr_data in, rd_en in, rd_data/full/empty/count out.
module sweep_upload_fifo #(
  parameter int DEPTH = 64,
  parameter int W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         Clk,
  input  logic         reset_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic wr_ok;
  always_comb begin
    full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty = wr_ptr_q == rd_ptr_q;
    count = wr_ptr_q - rd_ptr_q;
    wr_ok = wr_en && !full;
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en && !empty);
    rd_data = mem_q[rd_ptr_q[AW-1:0]];
  end
  always_ff @(posedge Clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  always_ff @(posedge Clk)
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
endmodule

// File: rtl/sweep_acq_uploader.sv
// sweep_acq_uploader: buffers sweep words and uploads them to USB with per-step DAC trailers and an end marker; ports Clk/reset_n, sweep data/pulses in, USB FIFO word/strobe out, done pulses and sticky error flags out.
module sweep_acq_uploader
  import sweep_acq_uploader_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter logic [15:0] DAC_TAG = DAC_TAG_DEF,
  parameter logic [15:0] END_TAG = END_TAG_DEF
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic [15:0] SweepACQData,
  input  logic        SweepACQData_en,
  input  logic        SingleDacDone,
  input  logic        ACQDone,
  input  logic [9:0]  CurrentDAC0,
  input  logic        UsbFifoFull,
  output logic [15:0] UsbFifoData,
  output logic        UsbFifoData_en,
  output logic        DataTransmitDone,
  output logic        SweepUploadDone,
  output logic        Overflow,
  output logic        ProtocolError
);
  localparam int AW = $clog2(FIFO_DEPTH);
  state_t state_q, state_d;
  logic [9:0] dac_q, dac_d;
  logic [AW:0] drain_q, drain_d, fifo_count;
  logic [15:0] out_data_q, out_data_d, ld_word, rd_data;
  logic out_valid_q, out_valid_d, acq_pend_q, acq_pend_d, dtd_q, dtd_d, sud_q, sud_d;
  logic ovf_q, ovf_d, perr_q, perr_d, fifo_full, fifo_empty, rd, ld, accept;
  sweep_upload_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
    .Clk(Clk), .reset_n(reset_n), .wr_en(SweepACQData_en), .wr_data(SweepACQData),
    .rd_en(rd), .rd_data(rd_data), .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
  );
  // A one-word output stage holds each word until the USB side can take it;
  // it is only reloaded while UsbFifoFull is low, so it never backs up.
  always_comb begin
    state_d = state_q;
    dac_d = dac_q;
    drain_d = drain_q;
    acq_pend_d = acq_pend_q | ACQDone;
    out_valid_d = out_valid_q & UsbFifoFull;
    out_data_d = out_data_q;
    dtd_d = 1'b0;
    sud_d = 1'b0;
    accept = SweepACQData_en & ~fifo_full;
    ovf_d = ovf_q | (SweepACQData_en & fifo_full);
    perr_d = perr_q | (ACQDone & acq_pend_q)
           | (SingleDacDone & (state_q != IDLE) & (state_q != STREAM));
    rd = 1'b0;
    ld = 1'b0;
    ld_word = rd_data;
    case (state_q)
      IDLE, STREAM: begin
        rd = !fifo_empty && !UsbFifoFull;
        ld = rd;
        if (SingleDacDone) begin
          // Count every word belonging to this step that is still buffered after this cycle.
          dac_d = CurrentDAC0;
          drain_d = fifo_count + (AW+1)'(accept) - (AW+1)'(rd);
          state_d = DRAIN;
        end else if (acq_pend_q && fifo_empty && !SweepACQData_en) state_d = END;
        else if (accept) state_d = STREAM;
      end
      DRAIN:
        if (drain_q == '0) state_d = TAG;
        else if (!UsbFifoFull) begin
          rd = 1'b1;
          ld = 1'b1;
          drain_d = drain_q - 1'b1;
        end
      TAG:
        if (!UsbFifoFull) begin
          ld = 1'b1;
          ld_word = DAC_TAG;
          state_d = DAC;
        end
      DAC:
        if (!UsbFifoFull) begin
          ld = 1'b1;
          ld_word = {{DAC_PAD_W{1'b0}}, dac_q};
          state_d = DONE_PULSE;
        end
      // The DAC word leaves the stage here; the pulse follows one cycle later.
      DONE_PULSE:
        if (!UsbFifoFull) begin
          dtd_d = 1'b1;
          state_d = STREAM;
        end
      END:
        if (!UsbFifoFull) begin
          ld = 1'b1;
          ld_word = END_TAG;
          acq_pend_d = 1'b0;
          state_d = END_PULSE;
        end
      END_PULSE:
        if (!UsbFifoFull) begin
          sud_d = 1'b1;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
    if (ld) begin
      out_data_d = ld_word;
      out_valid_d = 1'b1;
    end
  end
  always_ff @(posedge Clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      dac_q <= '0;
      drain_q <= '0;
      acq_pend_q <= 1'b0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      dtd_q <= 1'b0;
      sud_q <= 1'b0;
      ovf_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dac_q <= dac_d;
      drain_q <= drain_d;
      acq_pend_q <= acq_pend_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      dtd_q <= dtd_d;
      sud_q <= sud_d;
      ovf_q <= ovf_d;
      perr_q <= perr_d;
    end
  assign UsbFifoData = out_data_q;
  assign UsbFifoData_en = out_valid_q & ~UsbFifoFull;
  assign DataTransmitDone = dtd_q;
  assign SweepUploadDone = sud_q;
  assign Overflow = ovf_q;
  assign ProtocolError = perr_q;
endmodule

// File: tb/tb_sweep_acq_uploader.sv
// tb_sweep_acq_uploader: scoreboard bench; expected USB words and done pulses are queued in stimulus order and checked by a monitor.
module tb_sweep_acq_uploader;
  localparam int M_DTD = -1;
  localparam int M_SUD = -2;
  logic Clk = 1'b0, reset_n = 1'b0;
  logic [15:0] SweepACQData = '0;
  logic SweepACQData_en = 1'b0, SingleDacDone = 1'b0, ACQDone = 1'b0, UsbFifoFull = 1'b0;
  logic [9:0] CurrentDAC0 = '0;
  logic [15:0] UsbFifoData;
  logic UsbFifoData_en, DataTransmitDone, SweepUploadDone, Overflow, ProtocolError;
  int exp_q[$];
  int n_vec = 0, n_err = 0;
  bit in_rst = 1'b1, rand_full = 1'b0;

  sweep_acq_uploader #(.FIFO_DEPTH(64)) dut (
    .Clk(Clk), .reset_n(reset_n), .SweepACQData(SweepACQData), .SweepACQData_en(SweepACQData_en),
    .SingleDacDone(SingleDacDone), .ACQDone(ACQDone), .CurrentDAC0(CurrentDAC0),
    .UsbFifoFull(UsbFifoFull), .UsbFifoData(UsbFifoData), .UsbFifoData_en(UsbFifoData_en),
    .DataTransmitDone(DataTransmitDone), .SweepUploadDone(SweepUploadDone),
    .Overflow(Overflow), .ProtocolError(ProtocolError)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_chk(input string name, input int act);
    if (exp_q.size() == 0) chk({name, "_unexpected"}, act, -99);
    else chk(name, act, exp_q.pop_front());
  endtask

  always @(negedge Clk)
    if (!in_rst) begin
      if (UsbFifoData_en) begin
        chk("strobe_while_full", int'(UsbFifoFull), 0);
        pop_chk("usb_word", int'(UsbFifoData));
      end
      if (DataTransmitDone) pop_chk("data_transmit_done", M_DTD);
      if (SweepUploadDone) pop_chk("sweep_upload_done", M_SUD);
    end

  task automatic step();
    @(posedge Clk);
    #1;
    if (rand_full) UsbFifoFull = ($urandom_range(0, 9) < 3);
  endtask

  task automatic word(input logic [15:0] w, input bit expect_it);
    SweepACQData = w;
    SweepACQData_en = 1'b1;
    if (expect_it) exp_q.push_back(int'(w));
    step();
    SweepACQData_en = 1'b0;
  endtask

  task automatic sdd(input logic [9:0] dac, input bit with_w, input logic [15:0] w);
    if (with_w) begin
      SweepACQData = w;
      SweepACQData_en = 1'b1;
      exp_q.push_back(int'(w));
    end
    exp_q.push_back(32'hFFD0);
    exp_q.push_back(int'(dac));
    exp_q.push_back(M_DTD);
    CurrentDAC0 = dac;
    SingleDacDone = 1'b1;
    step();
    SingleDacDone = 1'b0;
    SweepACQData_en = 1'b0;
  endtask

  task automatic acq();
    exp_q.push_back(32'hFFEE);
    exp_q.push_back(M_SUD);
    ACQDone = 1'b1;
    step();
    ACQDone = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      step();
      i++;
    end
    chk({name, "_pending_left"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) step();
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_data"}, int'(UsbFifoData), 0);
    chk({name, "_en"}, int'(UsbFifoData_en), 0);
    chk({name, "_dtd"}, int'(DataTransmitDone), 0);
    chk({name, "_sud"}, int'(SweepUploadDone), 0);
    chk({name, "_ovf"}, int'(Overflow), 0);
    chk({name, "_perr"}, int'(ProtocolError), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    in_rst = 1'b0;
    repeat (2) step();

    for (int i = 1; i <= 3; i++) word(16'hA000 + 16'(i), 1'b1);
    sdd(10'h155, 1'b0, '0);
    wait_empty("basic_frame", 200);

    for (int i = 13; i <= 14; i++) word(16'hB000 + 16'(i), 1'b1);
    sdd(10'h0F0, 1'b1, 16'hB00F);
    step();
    word(16'hB010, 1'b1);
    wait_empty("coincident_word", 200);

    UsbFifoFull = 1'b1;
    sdd(10'h321, 1'b0, '0);
    repeat (19) step();
    UsbFifoFull = 1'b0;
    wait_empty("tag_stall", 200);

    chk("perr_before", int'(ProtocolError), 0);
    word(16'hD001, 1'b1);
    word(16'hD002, 1'b1);
    repeat (4) step();
    UsbFifoFull = 1'b1;
    sdd(10'h2AA, 1'b0, '0);
    acq();
    SingleDacDone = 1'b1;
    step();
    SingleDacDone = 1'b0;
    repeat (5) step();
    chk("perr_after_extra_sdd", int'(ProtocolError), 1);
    UsbFifoFull = 1'b0;
    wait_empty("acq_during_drain", 200);

    rand_full = 1'b1;
    for (int s = 0; s < 6; s++) begin
      int n = $urandom_range(1, 20);
      for (int k = 0; k < n; k++) begin
        word(16'($urandom), 1'b1);
        repeat ($urandom_range(0, 2)) step();
      end
      sdd(10'($urandom), 1'($urandom_range(0, 1)), 16'($urandom));
      for (int k = 0; k < $urandom_range(0, 3); k++) word(16'($urandom), 1'b1);
      wait_empty("random_step", 2000);
    end
    acq();
    wait_empty("random_end", 2000);
    rand_full = 1'b0;
    UsbFifoFull = 1'b0;

    chk("ovf_before", int'(Overflow), 0);
    UsbFifoFull = 1'b1;
    for (int i = 0; i < 70; i++) word(16'hC000 + 16'(i), i < 64);
    sdd(10'h3FF, 1'b0, '0);
    repeat (3) step();
    chk("ovf_after", int'(Overflow), 1);
    UsbFifoFull = 1'b0;
    wait_empty("overflow_frame", 500);

    UsbFifoFull = 1'b1;
    sdd(10'h1AB, 1'b0, '0);
    repeat (3) step();
    UsbFifoFull = 1'b0;
    step();
    UsbFifoFull = 1'b1;
    repeat (2) step();
    reset_n = 1'b0;
    in_rst = 1'b1;
    exp_q.delete();
    #1;
    chk_reset_outputs("midframe_reset");
    step();
    UsbFifoFull = 1'b0;
    step();
    chk_reset_outputs("midframe_reset_held");
    reset_n = 1'b1;
    in_rst = 1'b0;
    repeat (2) step();
    word(16'hE001, 1'b1);
    word(16'hE002, 1'b1);
    sdd(10'h0AA, 1'b0, '0);
    wait_empty("post_reset_frame", 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sweep_acq_uploader.md
SWEEP_ACQ_UPLOADER -- requirements
Module: sweep_acq_uploader

Interface
REQ-001 SHALL use parameter FIFO_DEPTH, default 64, meaning the internal buffer depth in 16-bit words (power of two, 16..512).
REQ-002 SHALL use parameter DAC_TAG, default 16'hFFD0, meaning the first trailer word emitted per DAC step.
REQ-003 SHALL use parameter END_TAG, default 16'hFFEE, meaning the end-of-sweep marker word.
REQ-004 Clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SweepACQData  input  16  sweep data word from the sweep acquisition controller.
REQ-007 SweepACQData_en  input  1  qualifies SweepACQData for one cycle.
REQ-008 SingleDacDone  input  1  one-cycle pulse marking the end of one DAC step.
REQ-009 ACQDone  input  1  one-cycle pulse marking the end of the whole sweep.
REQ-010 CurrentDAC0  input  10  DAC0 value of the step just finished.
REQ-011 UsbFifoFull  input  1  downstream USB FIFO full; no word is written while it is high.
REQ-012 UsbFifoData  output  16  word to the USB FIFO.
REQ-013 UsbFifoData_en  output  1  one-cycle write strobe for UsbFifoData.
REQ-014 DataTransmitDone  output  1  one-cycle pulse after a step's trailer has been written.
REQ-015 SweepUploadDone  output  1  one-cycle pulse after END_TAG has been written.
REQ-016 Overflow  output  1  sticky flag: a data word was dropped.
REQ-017 ProtocolError  output  1  sticky flag: a SingleDacDone or ACQDone pulse was ignored.

Function
REQ-018 The block SHALL write a word into the buffer on every SweepACQData_en cycle while the buffer is not full; when the buffer is full it SHALL drop the word and set Overflow.
REQ-019 UsbFifoData_en SHALL assert only when UsbFifoFull is low, with at most one word per cycle.
REQ-020 A data word accepted in cycle N SHALL reach UsbFifoData no earlier than cycle N+2 and no later than N+2 plus the number of UsbFifoFull-high cycles plus the number of words queued ahead of it.
REQ-021 The FSM SHALL have the states IDLE, STREAM, DRAIN, TAG, DAC, DONE_PULSE, END and END_PULSE.
REQ-022 IDLE/STREAM: buffered words are forwarded; a SingleDacDone pulse latches CurrentDAC0 and moves the FSM to DRAIN.
REQ-023 A SweepACQData_en in the same cycle as SingleDacDone SHALL belong to the finishing step, so it is emitted before the trailer.
REQ-024 DRAIN SHALL forward only the words accepted up to and including the SingleDacDone cycle, then go to TAG; words arriving later stay buffered and are sent after DONE_PULSE.
REQ-025 TAG SHALL write DAC_TAG, and DAC SHALL write {6'b0, latched DAC0}; each state holds while UsbFifoFull is high.
REQ-026 DONE_PULSE SHALL assert DataTransmitDone for exactly one cycle, one cycle after the DAC word was written, then return to STREAM.
REQ-027 An ACQDone pulse SHALL be latched as pending; once the FSM is in STREAM/IDLE and the buffer is empty, END SHALL write END_TAG, then END_PULSE SHALL assert SweepUploadDone for one cycle and return to IDLE.
REQ-028 A SingleDacDone pulse received while in DRAIN, TAG, DAC or DONE_PULSE SHALL be ignored and SHALL set ProtocolError; a second ACQDone while one is pending SHALL be handled the same way.
REQ-029 Buffer read/write pointers SHALL be log2(FIFO_DEPTH)+1 bits wide, with wrap-around by natural overflow and full/empty decided from the MSB comparison.
REQ-030 Simultaneous buffer read and write when the buffer is full SHALL drop the incoming word (full is evaluated before the read).

Reset
REQ-031 While reset_n is low: FSM in IDLE, buffer empty, all outputs 0, UsbFifoData = 16'h0000, pending flags and sticky flags cleared.
REQ-032 A reset asserted mid-frame SHALL abort the frame with no partial trailer after release; Overflow and ProtocolError SHALL clear only on reset.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding, the DAC_TAG/END_TAG defaults and the DAC pad width (6).
REQ-034 The buffer SHALL be a separate sub-module, sweep_upload_fifo: synchronous, first-word-fall-through, with full/empty outputs.

Verification
REQ-035 3 words A001..A003, then SingleDacDone with CurrentDAC0=10'h155, UsbFifoFull=0 -> USB sequence A001, A002, A003, FFD0, 0155, then DataTransmitDone pulses once.
REQ-036 UsbFifoFull held high for 20 cycles during TAG -> FFD0 is written once, after the release, and no strobe occurs while full.
REQ-037 70 back-to-back words with UsbFifoFull=1 (FIFO_DEPTH=64) -> 64 words delivered after release, Overflow=1, and the sweep data before the trailer are exactly the first 64 words.
REQ-038 SingleDacDone coincident with the last data word B00F, then a word B010 two cycles later -> B00F precedes FFD0, and B010 follows DataTransmitDone.
REQ-039 ACQDone during DRAIN -> trailer completes, then FFEE, then SweepUploadDone; a second SingleDacDone in TAG sets ProtocolError with no extra trailer.
REQ-040 reset_n asserted in the DAC state -> the 0xxx word is never written, all outputs go to 0, and a subsequent step produces a normal frame.
